// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader
//  Description : Byte-stream loader / readback engine for the 6502 memory
//                bus. Decodes WRITE, READ, RUN and HALT frames from the
//                command channel. While the loader owns the bus it drives
//                the RAM and holds the CPU in reset. RUN hands the bus to
//                the CPU and releases CPU reset.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   system clock, rising edge
//    reset      in   1   synchronous active-high reset
//    in_data    in   8   command/data byte
//    in_valid   in   1   in_data valid
//    in_ready   out  1   loader accepts a byte this cycle
//    out_data   out  8   readback byte
//    out_valid  out  1   out_data valid, held until accepted
//    out_ready  in   1   consumer accepts readback byte
//    cpu_ab     in  16   CPU address bus
//    cpu_do     in   8   CPU write data
//    cpu_we     in   1   CPU write enable
//    cpu_reset  out  1   CPU reset, high while the loader owns the bus
//    mem_ab     out 16   RAM address
//    mem_do     out  8   RAM write data
//    mem_we     out  1   RAM write enable
//    mem_di     in   8   RAM read data (one cycle after the address)
//    busy       out  1   frame in progress
// ============================================================================
module ram_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic        cpu_reset,
    output logic [15:0] mem_ab,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    input  logic [7:0]  mem_di,
    output logic        busy
);

    localparam logic [7:0] c_CMD_WRITE = 8'h01;
    localparam logic [7:0] c_CMD_READ  = 8'h02;
    localparam logic [7:0] c_CMD_RUN   = 8'h03;
    localparam logic [7:0] c_CMD_HALT  = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AH    = 3'd1,
        ST_AL    = 3'd2,
        ST_LEN   = 3'd3,
        ST_WDATA = 3'd4,
        ST_RADDR = 3'd5,
        ST_RWAIT = 3'd6,
        ST_RSEND = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state_q,     w_state_d;
    logic        r_mode_wr_q,   w_mode_wr_d;    // 1 = WRITE frame, 0 = READ
    logic [15:0] r_addr_q,      w_addr_d;
    logic [8:0]  r_count_q,     w_count_d;      // 9 bits so LEN=0 holds 256
    logic        r_owner_cpu_q, w_owner_cpu_d;  // 1 = CPU owns the RAM bus
    logic        r_cpu_reset_q, w_cpu_reset_d;
    logic [15:0] r_ld_ab_q,     w_ld_ab_d;
    logic [7:0]  r_ld_do_q,     w_ld_do_d;
    logic        r_ld_we_q,     w_ld_we_d;
    logic [7:0]  r_out_data_q,  w_out_data_d;
    logic        r_out_valid_q, w_out_valid_d;

    // ------------------------------------------------------------------
    // Handshakes and helpers
    // ------------------------------------------------------------------
    logic        w_in_ready;
    logic        w_in_fire;
    logic        w_out_fire;
    logic [15:0] w_addr_inc;
    logic [8:0]  w_count_dec;
    logic        w_last;

    // The read path stalls the command channel until the frame completes.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state_q)
            ST_IDLE, ST_AH, ST_AL, ST_LEN, ST_WDATA: w_in_ready = 1'b1;
            default:                                 w_in_ready = 1'b0;
        endcase
    end

    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = r_out_valid_q & out_ready;
    assign w_addr_inc  = r_addr_q + 16'd1;      // wraps 0xFFFF -> 0x0000
    assign w_count_dec = r_count_q - 9'd1;
    assign w_last      = (r_count_q == 9'd1);

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_mode_wr_d   = r_mode_wr_q;
        w_addr_d      = r_addr_q;
        w_count_d     = r_count_q;
        w_owner_cpu_d = r_owner_cpu_q;
        w_ld_ab_d     = r_ld_ab_q;
        w_ld_do_d     = r_ld_do_q;
        w_ld_we_d     = 1'b0;                    // write strobe is a one-cycle pulse
        w_out_data_d  = r_out_data_q;
        w_out_valid_d = r_out_valid_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_in_fire) begin
                    case (in_data)
                        c_CMD_WRITE: begin
                            w_mode_wr_d   = 1'b1;
                            w_owner_cpu_d = 1'b0;
                            w_state_d     = ST_AH;
                        end
                        c_CMD_READ: begin
                            w_mode_wr_d   = 1'b0;
                            w_owner_cpu_d = 1'b0;
                            w_state_d     = ST_AH;
                        end
                        c_CMD_RUN:  w_owner_cpu_d = 1'b1;
                        c_CMD_HALT: w_owner_cpu_d = 1'b0;
                        default:    w_state_d     = ST_IDLE;
                    endcase
                end
            end

            ST_AH: begin
                if (w_in_fire) begin
                    w_addr_d  = {in_data, r_addr_q[7:0]};
                    w_state_d = ST_AL;
                end
            end

            ST_AL: begin
                if (w_in_fire) begin
                    w_addr_d  = {r_addr_q[15:8], in_data};
                    w_state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                if (w_in_fire) begin
                    w_count_d = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    if (r_mode_wr_q) begin
                        w_state_d = ST_WDATA;
                    end else begin
                        // Present the address during RADDR so that the
                        // synchronous RAM returns it during RWAIT.
                        w_ld_ab_d = r_addr_q;
                        w_state_d = ST_RADDR;
                    end
                end
            end

            ST_WDATA: begin
                if (w_in_fire) begin
                    w_ld_ab_d = r_addr_q;
                    w_ld_do_d = in_data;
                    w_ld_we_d = 1'b1;
                    w_addr_d  = w_addr_inc;
                    w_count_d = w_count_dec;
                    if (w_last) begin
                        w_state_d = ST_IDLE;
                    end
                end
            end

            ST_RADDR: begin
                w_ld_ab_d = r_addr_q;
                w_state_d = ST_RWAIT;
            end

            ST_RWAIT: begin
                w_out_data_d  = mem_di;
                w_out_valid_d = 1'b1;
                w_state_d     = ST_RSEND;
            end

            ST_RSEND: begin
                if (w_out_fire) begin
                    w_out_valid_d = 1'b0;
                    w_addr_d      = w_addr_inc;
                    w_count_d     = w_count_dec;
                    w_ld_ab_d     = w_addr_inc;
                    w_state_d     = w_last ? ST_IDLE : ST_RADDR;
                end
            end

            default: w_state_d = ST_IDLE;
        endcase

        w_cpu_reset_d = ~w_owner_cpu_d;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_mode_wr_q   <= 1'b0;
            r_addr_q      <= 16'h0000;
            r_count_q     <= 9'd0;
            r_owner_cpu_q <= 1'b0;
            r_cpu_reset_q <= 1'b1;
            r_ld_ab_q     <= 16'h0000;
            r_ld_do_q     <= 8'h00;
            r_ld_we_q     <= 1'b0;
            r_out_data_q  <= 8'h00;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_mode_wr_q   <= w_mode_wr_d;
            r_addr_q      <= w_addr_d;
            r_count_q     <= w_count_d;
            r_owner_cpu_q <= w_owner_cpu_d;
            r_cpu_reset_q <= w_cpu_reset_d;
            r_ld_ab_q     <= w_ld_ab_d;
            r_ld_do_q     <= w_ld_do_d;
            r_ld_we_q     <= w_ld_we_d;
            r_out_data_q  <= w_out_data_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs and RAM bus multiplexer
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data_q;
    assign out_valid = r_out_valid_q;
    assign cpu_reset = r_cpu_reset_q;
    assign busy      = (r_state_q != ST_IDLE);

    // CPU path is combinational so the CPU sees the RAM exactly as if the
    // loader were absent; the loader path comes straight from registers.
    assign mem_ab = r_owner_cpu_q ? cpu_ab : r_ld_ab_q;
    assign mem_do = r_owner_cpu_q ? cpu_do : r_ld_do_q;
    assign mem_we = r_owner_cpu_q ? cpu_we : r_ld_we_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_loader
//  Description : Directed self-checking bench for ram_loader with a
//                synchronous single-port RAM model and a stand-in CPU.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic        cpu_reset;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic [7:0]  mem_di;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    ram_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cpu_ab    (cpu_ab),
        .cpu_do    (cpu_do),
        .cpu_we    (cpu_we),
        .cpu_reset (cpu_reset),
        .mem_ab    (mem_ab),
        .mem_do    (mem_do),
        .mem_we    (mem_we),
        .mem_di    (mem_di),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: address registered, data next cycle.
    logic [7:0] ram [0:65535];
    logic       ram_clr;
    int         we_count = 0;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
        end else begin
            if (mem_we === 1'b1) ram[mem_ab] <= mem_do;
            mem_di <= ram[mem_ab];
        end
    end

    always @(posedge clk) begin
        if (mem_we === 1'b1) we_count <= we_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accept_timeout", 32'(ok), 32'd1);
    endtask

    logic [7:0] rx_q [$];
    int         hold_err;
    int         extra_err;

    // READ frame; optionally toggles out_ready every cycle.
    task automatic read_frame(input logic [15:0] a, input int n, input bit toggle);
        bit         pend;
        bit         done;
        logic [7:0] prev;
        rx_q.delete();
        hold_err  = 0;
        extra_err = 0;
        pend      = 1'b0;
        done      = 1'b0;
        prev      = 8'h00;
        send(8'h02);
        send(a[15:8]);
        send(a[7:0]);
        send(8'(n));
        out_ready = 1'b1;
        for (int c = 0; c < 20 * n + 20; c++) begin
            @(negedge clk);
            if (pend && (!out_valid || out_data !== prev)) hold_err++;
            if (out_valid && out_ready) rx_q.push_back(out_data);
            pend = out_valid && !out_ready;
            prev = out_data;
            if (!busy && rx_q.size() >= n) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (toggle) out_ready = ~out_ready;
        end
        check("read_done_timeout", 32'(done), 32'd1);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) extra_err++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    int base;

    initial begin
        reset     = 1'b1;
        ram_clr   = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cpu_ab    = 16'h0000;
        cpu_do    = 8'h00;
        cpu_we    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        ram_clr = 1'b0;
        @(posedge clk);
        #1;

        // ---- reset state ----
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_ab",    32'(mem_ab),    32'h0000);
        check("rst_mem_do",    32'(mem_do),    32'h00);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h00);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // ---- WRITE 0x1300 LEN 3, continuous; then junk byte back-to-back ----
        base = we_count;
        send(8'h01); send(8'h13); send(8'h00); send(8'h03);
        send(8'h69);
        check("wr_busy_mid",   32'(busy),   32'd1);
        check("wr_we_first",   32'(mem_we), 32'd1);
        send(8'h47);
        check("wr_we_second",  32'(mem_we), 32'd1);
        send(8'h18);
        check("wr_busy_after", 32'(busy),   32'd0);
        check("wr_we_last",    32'(mem_we), 32'd1);
        check("wr_ab_last",    32'(mem_ab), 32'h1302);
        check("wr_do_last",    32'(mem_do), 32'h18);
        send(8'h7F);
        check("junk_busy",     32'(busy),     32'd0);
        check("junk_we",       32'(mem_we),   32'd0);
        check("junk_in_ready", 32'(in_ready), 32'd1);
        check("wr_we_count",   32'(we_count - base), 32'd3);
        check("ram_1300", 32'(ram[16'h1300]), 32'h69);
        check("ram_1301", 32'(ram[16'h1301]), 32'h47);
        check("ram_1302", 32'(ram[16'h1302]), 32'h18);

        // ---- READ 0x1300 LEN 3 with toggling out_ready ----
        read_frame(16'h1300, 3, 1'b1);
        check("rd_count", 32'(rx_q.size()), 32'd3);
        if (rx_q.size() == 3) begin
            check("rd_byte0", 32'(rx_q[0]), 32'h69);
            check("rd_byte1", 32'(rx_q[1]), 32'h47);
            check("rd_byte2", 32'(rx_q[2]), 32'h18);
        end
        check("rd_hold",  32'(hold_err),  32'd0);
        check("rd_extra", 32'(extra_err), 32'd0);
        check("rd_busy",  32'(busy),      32'd0);

        // ---- WRITE across address wrap ----
        send(8'h01); send(8'hFF); send(8'hFF); send(8'h02);
        send(8'hAA); send(8'hBB);
        @(posedge clk);
        #1;
        check("wrap_ffff", 32'(ram[16'hFFFF]), 32'hAA);
        check("wrap_0000", 32'(ram[16'h0000]), 32'hBB);

        // ---- LEN=0 write of 256 bytes at 0x2000 ----
        base = we_count;
        send(8'h01); send(8'h20); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i ^ 8'h5A));
        check("len0_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("len0_we_count", 32'(we_count - base), 32'd256);
        check("len0_first",    32'(ram[16'h2000]), 32'h5A);
        check("len0_last",     32'(ram[16'h20FF]), 32'hA5);
        check("len0_beyond",   32'(ram[16'h2100]), 32'h00);

        // ---- program load (CLC; CLD; LDA #$69; ADC #$47; STA $1300), RUN ----
        send(8'h01); send(8'h00); send(8'h00); send(8'h09);
        send(8'h18); send(8'hD8); send(8'hA9); send(8'h69);
        send(8'h69); send(8'h47); send(8'h8D); send(8'h00); send(8'h13);
        @(posedge clk);
        #1;
        check("prog_0000", 32'(ram[16'h0000]), 32'h18);
        check("prog_0008", 32'(ram[16'h0008]), 32'h13);
        check("prerun_cpu_reset", 32'(cpu_reset), 32'd1);
        send(8'h03);
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check("run_busy",      32'(busy),      32'd0);
        cpu_ab = 16'h1234;
        cpu_do = 8'h5A;
        #1;
        check("run_ab_follow", 32'(mem_ab), 32'h1234);
        check("run_do_follow", 32'(mem_do), 32'h5A);
        // Stand-in CPU performs the STA of the ADC result 0x69+0x47=0xB0.
        cpu_ab = 16'h1300;
        cpu_do = 8'hB0;
        cpu_we = 1'b1;
        #1;
        check("run_we_follow", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        check("run_cpu_write", 32'(ram[16'h1300]), 32'hB0);

        // ---- HALT: CPU writes blocked ----
        send(8'h04);
        check("halt_cpu_reset", 32'(cpu_reset), 32'd1);
        cpu_ab = 16'h1301;
        cpu_do = 8'h66;
        cpu_we = 1'b1;
        #1;
        check("halt_we_blocked", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        check("halt_ram_kept", 32'(ram[16'h1301]), 32'h47);

        read_frame(16'h1300, 1, 1'b0);
        check("cpuvis_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) check("cpuvis_byte", 32'(rx_q[0]), 32'hB0);

        // ---- reset during WDATA after 1 of 4 bytes ----
        base = we_count;
        send(8'h01); send(8'h30); send(8'h00); send(8'h04);
        send(8'h11);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_we",        32'(mem_we),    32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_ram0",     32'(ram[16'h3000]), 32'h11);
        check("mid_rst_ram1",     32'(ram[16'h3001]), 32'h00);
        check("mid_rst_we_count", 32'(we_count - base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_loader.md
# ram_loader

Bus-side loader and readback engine for the 6502 memory bus. It takes a byte-stream command channel and owns the RAM bus (ab/do/we/di) while it writes program images or reads memory back, holding the CPU in reset meanwhile. On a RUN command it hands the bus to the CPU and releases CPU reset. It replaces hand-poked `ram[]` initialisation and end-of-run memory dumps with a synthesizable path into the same single-port synchronous RAM.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  8  command/data byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready at posedge
- out_data  out  8  readback byte
- out_valid  out  1  out_data valid; held until accepted
- out_ready  in  1  consumer accepts; transfer = out_valid & out_ready at posedge
- cpu_ab  in  16  CPU address bus
- cpu_do  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_reset  out  1  reset to CPU; high while loader owns bus
- mem_ab  out  16  RAM address
- mem_do  out  8  RAM write data
- mem_we  out  1  RAM write enable
- mem_di  in  8  RAM read data; RAM registers address, data for address presented in cycle N is valid in cycle N+1
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Frame: CMD, ADDR_HI, ADDR_LO, LEN, then LEN data bytes (WRITE only). LEN=0 means 256.
- CMD 0x01 WRITE, 0x02 READ, 0x03 RUN, 0x04 HALT; any other byte consumed and ignored, stays IDLE.
- RUN/HALT are single-byte frames (no address/len).
- States: IDLE, AH, AL, LEN, WDATA, RADDR, RWAIT, RSEND.
- IDLE: on accepted byte: 0x01→AH (mode W), 0x02→AH (mode R), 0x03→owner=CPU, 0x04→owner=loader; else IDLE.
- Accepting WRITE or READ sets owner=loader (implicit HALT); owner stays loader after the frame until RUN.
- AH→AL→LEN on each accepted byte, loading addr[15:8], addr[7:0], count.
- LEN→WDATA (mode W) or RADDR (mode R).
- WDATA: each accepted byte registers mem_ab=addr, mem_do=byte, mem_we=1 for exactly the following cycle; addr+1 (16-bit, 0xFFFF wraps to 0x0000), count-1; last byte→IDLE.
- RADDR: mem_ab=addr, mem_we=0 → RWAIT. RWAIT: capture mem_di into out_data, out_valid=1 → RSEND. RSEND: on out_ready, out_valid=0, addr+1 (wrap), count-1; count exhausted→IDLE, else RADDR.
- Bus mux: owner=CPU → mem_ab/mem_do/mem_we = cpu_* combinationally; owner=loader → loader registers; mem_we from loader is 0 outside WDATA writes.
- cpu_reset = (owner==loader), registered.

## Timing
- Reset values: state IDLE, owner=loader, cpu_reset=1, mem_we=0, mem_ab=0, mem_do=0, out_valid=0, out_data=0, busy=0, in_ready=1 in cycle after reset deasserts.
- in_ready=1 in IDLE, AH, AL, LEN, WDATA; 0 in RADDR, RWAIT, RSEND.
- Write throughput 1 byte/cycle; write lands in RAM one cycle after acceptance.
- Read: 3 cycles/byte minimum (RADDR, RWAIT, RSEND with out_ready=1); out_data stable while out_valid high.
- RUN: cpu_reset low and owner=CPU the cycle after RUN accepted. HALT: cpu_reset high and loader owns bus the cycle after; any CPU write in that cycle is dropped.
- Reset mid-frame: frame abandoned, no stray mem_we, out_valid cleared, owner=loader.
- Final write of a frame and acceptance of next CMD may occur in consecutive cycles.

## Test plan
- WRITE 0x1300 LEN 3 {0x69,0x47,0x18} with in_valid continuous → three consecutive mem_we pulses, RAM[0x1300..0x1302] = 69,47,18; busy falls after last.
- READ 0x1300 LEN 3, out_ready toggling 1/0 → out_data 69,47,18 in order, each held until accepted, no duplicates.
- WRITE 0xFFFF LEN 2 {0xAA,0xBB} → RAM[0xFFFF]=AA, RAM[0x0000]=BB; LEN=0 write → exactly 256 mem_we pulses.
- Load ADC program at 0x0000 then RUN → cpu_reset low next cycle, mem_ab follows cpu_ab; HALT → cpu_reset high, CPU writes blocked; READ 0x1300 returns CPU-visible data.
- Byte 0x7F in IDLE → consumed, state IDLE, no bus activity.
- Assert reset during WDATA after 1 of 4 bytes → only first byte written, state IDLE, cpu_reset=1, in_ready=1 next cycle.
